// File: rtl/glb_axil_reg_bridge_if.sv
// glb_axil_reg_bridge_if: AXI4-Lite slave channels plus GLB config register request/return signals
// Ports: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready,
//        araddr/arvalid/arready, rdata/rresp/rvalid/rready (AXI-Lite);
//        wr_en/wr_clk_en/wr_addr/wr_data, rd_en/rd_clk_en/rd_addr (register request);
//        rd_data/rd_data_valid (register return).
// Modports: slave = the bridge, master = host plus register target.
interface glb_axil_reg_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic                  wr_en;
  logic                  wr_clk_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  rd_clk_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready, rd_data, rd_data_valid,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
           wr_en, wr_clk_en, wr_addr, wr_data, rd_en, rd_clk_en, rd_addr
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready, rd_data, rd_data_valid,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
           wr_en, wr_clk_en, wr_addr, wr_data, rd_en, rd_clk_en, rd_addr
  );
endinterface

// File: rtl/glb_axil_reg_bridge.sv
// glb_axil_reg_bridge: AXI4-Lite slave issuing single-cycle GLB config register write/read strobes
// Ports: clk, reset (sync, active-high); bus (glb_axil_reg_bridge_if.slave) carries the AXI-Lite
//        channels, the register write/read request outputs and the register read return inputs.
// One transaction outstanding; read/write priority alternates; read return is bounded by RD_TIMEOUT.
module glb_axil_reg_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  glb_axil_reg_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR, WR_HOLD, BRESP, RD, RD_WAIT, RRESP} state_t;
  localparam logic [7:0] TO = 8'(RD_TIMEOUT);
  state_t state_q, state_d;
  logic prio_q, prio_d, awready_q, awready_d, arready_q, arready_d;
  logic wr_en_q, wr_en_d, wr_ce_q, wr_ce_d, rd_en_q, rd_en_d, rd_ce_q, rd_ce_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d, rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic acc, take_wr, take_rd, werr, rerr, rd_ph, rd_ok, rd_fail;
  // A ready is raised one cycle after eligibility is seen in IDLE; the handshake (accept)
  // happens in the cycle that ready is high, so IDLE leaves on acc.
  assign acc     = awready_q | arready_q;
  assign take_wr = bus.awvalid && bus.wvalid && (prio_q || !bus.arvalid);
  assign take_rd = bus.arvalid && !take_wr;
  assign werr    = bus.awaddr[1:0] != 2'b00 || bus.wstrb != 4'hF;
  assign rerr    = bus.araddr[1:0] != 2'b00;
  assign rd_ph   = state_q == RD || state_q == RD_WAIT;
  assign rd_ok   = rd_ph && bus.rd_data_valid;
  assign rd_fail = (arready_q && rerr) || (state_q == RD_WAIT && !bus.rd_data_valid && cnt_q == TO);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b1;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_ce_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_ce_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wr_en_q   <= wr_en_d;
      wr_ce_q   <= wr_ce_d;
      rd_en_q   <= rd_en_d;
      rd_ce_q   <= rd_ce_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = awready_q ? (werr ? BRESP : WR) : arready_q ? (rerr ? RRESP : RD) : IDLE;
      WR:      state_d = WR_HOLD;
      WR_HOLD: state_d = BRESP;
      BRESP:   state_d = bus.bready ? IDLE : BRESP;
      RD:      state_d = bus.rd_data_valid ? RRESP : RD_WAIT;
      RD_WAIT: state_d = (bus.rd_data_valid || cnt_q == TO) ? RRESP : RD_WAIT;
      RRESP:   state_d = bus.rready ? IDLE : RRESP;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    awready_d = state_q == IDLE && !acc && take_wr;
    arready_d = state_q == IDLE && !acc && take_rd;
    prio_d    = acc ? !prio_q : prio_q;
    wr_en_d   = state_d == WR;
    wr_ce_d   = state_d == WR || state_d == WR_HOLD;
    rd_en_d   = state_d == RD;
    rd_ce_d   = state_d == RD || state_d == RD_WAIT;
    bvalid_d  = state_d == BRESP;
    rvalid_d  = state_d == RRESP;
    wr_addr_d = awready_q ? bus.awaddr : wr_addr_q;
    wr_data_d = awready_q ? bus.wdata : wr_data_q;
    rd_addr_d = arready_q ? bus.araddr : rd_addr_q;
    bresp_d   = awready_q ? (werr ? 2'b10 : 2'b00) : bresp_q;
    cnt_d     = state_q == RD ? 8'd1 : state_q == RD_WAIT ? cnt_q + 8'd1 : cnt_q;
    rdata_d   = rd_ok ? bus.rd_data : rd_fail ? '0 : rdata_q;
    rresp_d   = rd_ok ? 2'b00 : rd_fail ? 2'b10 : rresp_q;
  end
  assign bus.awready   = awready_q;
  assign bus.wready    = awready_q;
  assign bus.arready   = arready_q;
  assign bus.bvalid    = bvalid_q;
  assign bus.bresp     = bresp_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rresp     = rresp_q;
  assign bus.rdata     = rdata_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_clk_en = wr_ce_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_clk_en = rd_ce_q;
  assign bus.rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_glb_axil_reg_bridge.sv
// tb_glb_axil_reg_bridge: scoreboard bench for the AXI-Lite to GLB config register bridge
module tb_glb_axil_reg_bridge;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  glb_axil_reg_bridge_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
  glb_axil_reg_bridge #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int checks = 0, errors = 0, cyc = 0;
  int rd_delay = 0;
  logic [31:0] rd_val = 32'h0;
  int wr_ce_cnt = 0, rd_ce_cnt = 0, wr_en_cnt = 0, rd_en_cnt = 0;
  logic [43:0] wq[$];
  logic [11:0] raq[$];
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  string order = "";
  logic [100:0] outs;
  assign outs = {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid, bus.rresp,
                 bus.rdata, bus.wr_en, bus.wr_clk_en, bus.wr_addr, bus.wr_data, bus.rd_en,
                 bus.rd_clk_en, bus.rd_addr};
  always @(posedge clk) cyc++;
  // Scoreboard: pop expectations as the DUT produces strobes and responses
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_clk_en) wr_ce_cnt++;
      if (bus.rd_clk_en) rd_ce_cnt++;
      if (bus.awready) order = {order, "W"};
      if (bus.arready) order = {order, "R"};
      if (bus.wr_en) begin
        logic [43:0] e;
        wr_en_cnt++;
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_strobe: unexpected wr_en addr=%h data=%h", bus.wr_addr, bus.wr_data);
        end else begin
          e = wq.pop_front();
          if ({bus.wr_addr, bus.wr_data} !== e) begin
            errors++;
            $display("FAIL wr_strobe: got %h/%h expected %h/%h", bus.wr_addr, bus.wr_data, e[43:32], e[31:0]);
          end
        end
      end
      if (bus.rd_en) begin
        logic [11:0] e;
        rd_en_cnt++;
        checks++;
        if (raq.size() == 0) begin
          errors++;
          $display("FAIL rd_strobe: unexpected rd_en addr=%h", bus.rd_addr);
        end else begin
          e = raq.pop_front();
          if (bus.rd_addr !== e) begin
            errors++;
            $display("FAIL rd_strobe: got addr %h expected %h", bus.rd_addr, e);
          end
        end
      end
      if (bus.bvalid && bus.bready) begin
        logic [1:0] e;
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL bresp: unexpected bvalid bresp=%h", bus.bresp);
        end else begin
          e = bq.pop_front();
          if (bus.bresp !== e) begin
            errors++;
            $display("FAIL bresp: got %h expected %h", bus.bresp, e);
          end
        end
      end
      if (bus.rvalid && bus.rready) begin
        logic [33:0] e;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rresp: unexpected rvalid rresp=%h rdata=%h", bus.rresp, bus.rdata);
        end else begin
          e = rq.pop_front();
          if ({bus.rresp, bus.rdata} !== e) begin
            errors++;
            $display("FAIL rresp: got %h/%h expected %h/%h", bus.rresp, bus.rdata, e[33:32], e[31:0]);
          end
        end
      end
    end
  end
  // Register target: returns rd_val rd_delay cycles after rd_en (never when rd_delay < 0)
  initial begin
    int cd;
    cd = -1;
    forever begin
      @(negedge clk);
      bus.rd_data_valid = 1'b0;
      if (cd > 0) cd--;
      if (cd == 0) begin
        bus.rd_data_valid = 1'b1;
        cd = -1;
      end else if (bus.rd_en && rd_delay >= 0) begin
        if (rd_delay == 0) bus.rd_data_valid = 1'b1;
        else cd = rd_delay;
      end
      bus.rd_data = bus.rd_data_valid ? rd_val : 32'hDEAD_BEEF;
    end
  end
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit want_resp, output int lat);
    bit err;
    int n, t;
    err = a[1:0] != 2'b00 || s != 4'hF;
    if (!err) wq.push_back({a, d});
    if (want_resp) bq.push_back(err ? 2'b10 : 2'b00);
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
      errors++;
      $display("FAIL aw_w_handshake: awready=%b wready=%b required 1/1", bus.awready, bus.wready);
    end
    t = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.awaddr = 12'hFFF; bus.wdata = '1; bus.wstrb = 4'h0;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.bvalid !== 1'b1) begin
      errors++;
      $display("FAIL bvalid_wait: bvalid=%b required 1", bus.bvalid);
    end
    lat = cyc - t;
    if (bus.bready) @(negedge clk);
  endtask
  task automatic do_read(input logic [11:0] a, input logic [33:0] exp, output int lat);
    bit err;
    int n, t;
    err = a[1:0] != 2'b00;
    if (!err) raq.push_back(a);
    rq.push_back(err ? {2'b10, 32'h0} : exp);
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.arready !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake: arready=%b required 1", bus.arready);
    end
    t = cyc;
    @(negedge clk);
    bus.arvalid = 1'b0; bus.araddr = 12'hFFF;
    n = 0;
    while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rvalid_wait: rvalid=%b required 1", bus.rvalid);
    end
    lat = cyc - t;
    if (bus.rready) @(negedge clk);
  endtask
  task automatic clr_cnt();
    wr_ce_cnt = 0; rd_ce_cnt = 0; wr_en_cnt = 0; rd_en_cnt = 0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    reset = 1'b0;
  endtask
  task automatic test_write();
    int lat;
    clr_cnt();
    do_write(12'h010, 32'hA5A5_0001, 4'hF, 1'b1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d required 3", lat); end
    checks++;
    if (wr_ce_cnt !== 2) begin errors++; $display("FAIL wr_clk_en_cycles: got %0d required 2", wr_ce_cnt); end
    checks++;
    if (wr_en_cnt !== 1) begin errors++; $display("FAIL wr_en_count: got %0d required 1", wr_en_cnt); end
  endtask
  task automatic test_read();
    int lat;
    clr_cnt();
    rd_delay = 3; rd_val = 32'h1234_5678;
    do_read(12'h010, {2'b00, 32'h1234_5678}, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL read_latency_d3: got %0d required 5", lat); end
    checks++;
    if (rd_ce_cnt !== 4) begin errors++; $display("FAIL rd_clk_en_cycles: got %0d required 4", rd_ce_cnt); end
    checks++;
    if (rd_en_cnt !== 1) begin errors++; $display("FAIL rd_en_count: got %0d required 1", rd_en_cnt); end
    rd_delay = 0; rd_val = 32'hCAFE_0014;
    do_read(12'h014, {2'b00, 32'hCAFE_0014}, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL read_latency_d0: got %0d required 2", lat); end
  endtask
  task automatic test_timeout();
    int lat;
    clr_cnt();
    rd_delay = -1;
    do_read(12'h020, {2'b10, 32'h0}, lat);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL timeout_latency: got %0d required 18", lat); end
    checks++;
    if (rd_ce_cnt !== 17) begin errors++; $display("FAIL timeout_rd_clk_en: got %0d required 17", rd_ce_cnt); end
  endtask
  task automatic test_errors();
    int lat;
    clr_cnt();
    do_write(12'h012, 32'h1111_2222, 4'hF, 1'b1, lat);
    do_write(12'h010, 32'h3333_4444, 4'h3, 1'b1, lat);
    do_read(12'h006, {2'b10, 32'h0}, lat);
    checks++;
    if (wr_en_cnt + rd_en_cnt !== 0) begin
      errors++;
      $display("FAIL error_no_strobe: got %0d strobes required 0", wr_en_cnt + rd_en_cnt);
    end
  endtask
  task automatic test_back_to_back();
    int l1, l2;
    test_reset();
    clr_cnt();
    order = "";
    rd_delay = 0; rd_val = 32'h0BB0_0001;
    fork
      do_write(12'h100, 32'h0000_0100, 4'hF, 1'b1, l1);
      do_read(12'h104, {2'b00, 32'h0BB0_0001}, l2);
    join
    do_write(12'h108, 32'h0000_0108, 4'hF, 1'b1, l1);
    fork
      do_write(12'h10C, 32'h0000_010C, 4'hF, 1'b1, l1);
      do_read(12'h110, {2'b00, 32'h0BB0_0001}, l2);
    join
    checks++;
    if (order != "WRWRW") begin errors++; $display("FAIL arbitration_order: got %s required WRWRW", order); end
    checks++;
    if (wr_en_cnt !== 3 || rd_en_cnt !== 2) begin
      errors++;
      $display("FAIL b2b_strobes: got wr=%0d rd=%0d required 3/2", wr_en_cnt, rd_en_cnt);
    end
  endtask
  task automatic test_reset_mid();
    int lat;
    bus.bready = 1'b0;
    do_write(12'h030, 32'h0BAD_0030, 4'hF, 1'b0, lat);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_hold: got %b required 1", bus.bvalid); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h required 0", outs); end
    reset = 1'b0;
    bus.bready = 1'b1;
    do_write(12'h034, 32'h55AA_0034, 4'hF, 1'b1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL post_reset_write_latency: got %0d required 3", lat); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = 4'h0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    bus.rd_data = '0; bus.rd_data_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() + raq.size() + bq.size() + rq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d/%0d/%0d entries left required 0",
               wq.size(), raq.size(), bq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/glb_axil_reg_bridge.md
Name: glb_axil_reg_bridge

Overview:
- AXI4-Lite slave that turns host configuration accesses into single-cycle register write/read strobes on the global buffer configuration register interface, with matching clock enables.
- Sits directly upstream of the GLB config register interface; its outputs drive wr_en, wr_clk_en, wr_addr, wr_data, rd_en, rd_clk_en and rd_addr, and it consumes rd_data and rd_data_valid.
- Allows one outstanding transaction at a time, alternates priority between reads and writes, and enforces a read-response timeout.

Parameters:
- ADDR_WIDTH, 12, AXI and register address width.
- DATA_WIDTH, 32, data width; fixed at 32 (wstrb is 4 bits).
- RD_TIMEOUT, 16, maximum number of cycles to wait for rd_data_valid after rd_en; legal range 2..255.

Ports:
- clk  in  1  clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- awaddr  in  ADDR_WIDTH, awvalid  in  1, awready  out  1  AXI-Lite write address channel.
- wdata  in  DATA_WIDTH, wstrb  in  4, wvalid  in  1, wready  out  1  AXI-Lite write data channel.
- bresp  out  2, bvalid  out  1, bready  in  1  AXI-Lite write response channel.
- araddr  in  ADDR_WIDTH, arvalid  in  1, arready  out  1  AXI-Lite read address channel.
- rdata  out  DATA_WIDTH, rresp  out  2, rvalid  out  1, rready  in  1  AXI-Lite read data channel.
- wr_en  out  1, wr_clk_en  out  1, wr_addr  out  ADDR_WIDTH, wr_data  out  DATA_WIDTH  register write request.
- rd_en  out  1, rd_clk_en  out  1, rd_addr  out  ADDR_WIDTH  register read request.
- rd_data  in  DATA_WIDTH, rd_data_valid  in  1  register read return.

Behaviour:
- Reset: all valid, ready, en and clk_en outputs are 0; addr, data and rdata are 0; bresp and rresp are 0; FSM goes to IDLE; prio_wr is set to 1.
- States: IDLE, WR, WR_HOLD, BRESP, RD, RD_WAIT, RRESP. All outputs are registered.
- Write accept (IDLE):
  - A write is eligible only when awvalid and wvalid are both high.
  - When eligible, awready and wready pulse together for exactly one cycle.
  - awaddr, wdata and wstrb are latched in that cycle.
- Read accept (IDLE): arvalid high makes a read eligible; arready pulses for one cycle and araddr is latched.
- Arbitration:
  - If only one of read or write is eligible, it is accepted.
  - If both are eligible, a write wins when prio_wr=1, otherwise the read wins.
  - prio_wr toggles after every accepted transaction.
  - No handshake ready is asserted outside IDLE.
- Error checks, applied at accept:
  - Error if addr[1:0]!=0, or if wstrb!=4'hF on a write.
  - An erroring transaction skips the register strobe, goes straight to BRESP/RRESP with resp=2'b10 (SLVERR) and rdata=0.
- Write sequence:
  - WR lasts 1 cycle: wr_en=1, wr_clk_en=1, wr_addr and wr_data valid.
  - WR_HOLD lasts 1 cycle: wr_en=0, wr_clk_en=1 (gives the gated clock one extra edge).
  - BRESP: bvalid=1, bresp=OKAY, held until bready. Leave on the cycle bvalid&&bready, returning to IDLE.
- Read sequence:
  - RD lasts 1 cycle: rd_en=1, rd_clk_en=1.
  - RD_WAIT: rd_clk_en stays 1 and a counter counts from 1.
  - rd_data_valid is sampled in the RD cycle and in every RD_WAIT cycle.
  - On the first rd_data_valid, capture rd_data into rdata and set rresp=OKAY.
  - If the counter reaches RD_TIMEOUT with no valid, set rdata=0 and rresp=SLVERR.
  - Either way, go to RRESP with rd_clk_en=0.
  - RRESP: rvalid held until rready.
- Any rd_data_valid seen outside RD/RD_WAIT is ignored.
- Write-to-read ordering is guaranteed because only one transaction is ever outstanding.
- Min latency from accept to response valid: 3 cycles for a write; 2 cycles for a read when valid returns in the RD cycle.
- Reset asserted mid-transaction returns every output to its reset value on the next edge; the in-flight transaction is dropped with no response.
- Per AXI rules: bvalid and rvalid, once raised, do not drop until handshake; AXI inputs are not required to be held after accept.

Test Plan:
- Write awaddr=0x010, wdata=0xA5A5_0001, wstrb=F, bready=1 -> one cycle of wr_en with wr_addr=0x010, wr_data=0xA5A5_0001; wr_clk_en high for 2 cycles; bvalid with bresp=0 three cycles after accept.
- Read araddr=0x010, model returns rd_data=0x1234_5678 with valid 3 cycles after rd_en -> rd_en pulses once; rd_clk_en high for 4 cycles; rdata=0x1234_5678, rresp=0.
- Read with rd_data_valid never asserted, RD_TIMEOUT=16 -> rvalid after the timeout, rdata=0, rresp=2; rd_clk_en then low.
- AW, W and AR all valid in the same cycle, twice back-to-back -> first accepted is the write, second is the read; exactly one strobe per transaction.
- Misaligned awaddr=0x012, and wstrb=4'h3 -> no wr_en, bresp=2; misaligned araddr=0x006 -> no rd_en, rresp=2.
- bready held low 5 cycles, then reset asserted -> bvalid drops the cycle after reset; next write completes normally.
